// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared helpers for the branch history table predictor
package bp_pkg;

   // Widest value the saturating helpers operate on; callers cast to their own width.
   localparam int SAT_MAX_W = 64;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Index width for a table of the given depth (never narrower than one bit).
   function automatic int idx_w(input int entries);
      return (entries < 2) ? 1 : clog2(entries);
   endfunction

   // Weakly-not-taken value: 2^(w-1)-1, which is 0 for a one-bit counter.
   function automatic logic [SAT_MAX_W-1:0] ctr_init(input int w);
      return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
   endfunction

   function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                    input int w);
      logic [SAT_MAX_W-1:0] max_v;
      max_v = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
      return (v >= max_v) ? v : v + SAT_MAX_W'(1);
   endfunction

   function automatic logic [SAT_MAX_W-1:0] sat_dec(input logic [SAT_MAX_W-1:0] v);
      return (v == '0) ? v : v - SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit saturating up/down counter with synchronous load-on-reset
module sat_counter
   import bp_pkg::*;
#(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   input  logic [W-1:0] init,
   output logic [W-1:0] q
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   // Next value: reset loads init, otherwise step toward the requested rail and stick there.
   always_comb begin
      q_d = q_q;
      if (reset) begin
         q_d = init;
      end else if (inc && !dec) begin
         q_d = W'(sat_inc(SAT_MAX_W'(q_q), W));
      end else if (dec && !inc) begin
         q_d = W'(sat_dec(SAT_MAX_W'(q_q)));
      end
   end

   // Counter state register.
   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - bimodal/gshare branch history table with perf counters
module branch_predictor_bht
   import bp_pkg::*;
#(
   parameter  int ADDR_W  = 32,
   parameter  int ENTRIES = 64,
   parameter  int CTR_W   = 2,
   parameter  int GHR_W   = 0,
   parameter  int PERF_W  = 32,
   localparam int IDX_W   = idx_w(ENTRIES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lookup_valid,
   input  logic [ADDR_W-1:0] lookup_pc,
   input  logic [ADDR_W-1:0] lookup_offset,
   output logic              prediction,
   output logic [ADDR_W-1:0] branch_addr,
   output logic [IDX_W-1:0]  pred_index,
   input  logic              update_valid,
   input  logic [IDX_W-1:0]  update_index,
   input  logic              update_taken,
   input  logic              update_mispredict,
   output logic [PERF_W-1:0] perf_lookups,
   output logic [PERF_W-1:0] perf_mispredicts
);

   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

   logic [IDX_W-1:0] base_index;
   logic [CTR_W-1:0] ctr [ENTRIES];

   // Instructions are word aligned, so the two LSBs carry no information.
   assign base_index = lookup_pc[IDX_W+1:2];

   // PC bits above the index only feed the target adder.
   logic unused_pc;
   assign unused_pc = ^{lookup_pc[ADDR_W-1:IDX_W+2], lookup_pc[1:0]};

   generate
      if (GHR_W > 0) begin : g_gshare
         logic [GHR_W-1:0] ghr_d;
         logic [GHR_W-1:0] ghr_q;

         // History shifts in the resolved outcome; it only moves at resolve, so it never needs repair.
         always_comb begin
            ghr_d = ghr_q;
            if (reset) begin
               ghr_d = '0;
            end else if (update_valid) begin
               ghr_d = GHR_W'({ghr_q, update_taken});
            end
         end

         // Global history register.
         always_ff @(posedge clk) begin
            ghr_q <= ghr_d;
         end

         assign pred_index = base_index ^ IDX_W'(ghr_q);
      end else begin : g_bimodal
         assign pred_index = base_index;
      end
   endgenerate

   // One saturating counter per table entry, trained only by a resolve that addresses it.
   generate
      for (genvar i = 0; i < ENTRIES; i++) begin : g_table
         logic hit;
         assign hit = update_valid && (update_index == IDX_W'(i));
         sat_counter #(.W(CTR_W)) u_ctr (
            .clk   (clk),
            .reset (reset),
            .inc   (hit && update_taken),
            .dec   (hit && !update_taken),
            .init  (CTR_INIT),
            .q     (ctr[i])
         );
      end
   endgenerate

   // Lookup reads the registered counter, so a same-cycle update is seen one cycle later.
   assign prediction  = lookup_valid && !reset && ctr[pred_index][CTR_W-1];
   assign branch_addr = lookup_pc + lookup_offset;

   sat_counter #(.W(PERF_W)) u_perf_lookups (
      .clk   (clk),
      .reset (reset),
      .inc   (lookup_valid),
      .dec   (1'b0),
      .init  ('0),
      .q     (perf_lookups)
   );

   sat_counter #(.W(PERF_W)) u_perf_mispredicts (
      .clk   (clk),
      .reset (reset),
      .inc   (update_valid && update_mispredict),
      .dec   (1'b0),
      .init  ('0),
      .q     (perf_mispredicts)
   );

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed self-checking bench for branch_predictor_bht
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        reset;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic [31:0] lookup_offset;
   logic        update_valid;
   logic [5:0]  update_index;
   logic        update_taken;
   logic        update_mispredict;

   logic        d1_prediction;
   logic [31:0] d1_branch_addr;
   logic [5:0]  d1_pred_index;
   logic [31:0] d1_perf_lookups;
   logic [31:0] d1_perf_mispredicts;

   logic        d2_prediction;
   logic [31:0] d2_branch_addr;
   logic [5:0]  d2_pred_index;
   logic [3:0]  d2_perf_lookups;
   logic [3:0]  d2_perf_mispredicts;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_lk  = 0;

   always #5 clk = ~clk;

   branch_predictor_bht u_dut1 (
      .clk               (clk),
      .reset             (reset),
      .lookup_valid      (lookup_valid),
      .lookup_pc         (lookup_pc),
      .lookup_offset     (lookup_offset),
      .prediction        (d1_prediction),
      .branch_addr       (d1_branch_addr),
      .pred_index        (d1_pred_index),
      .update_valid      (update_valid),
      .update_index      (update_index),
      .update_taken      (update_taken),
      .update_mispredict (update_mispredict),
      .perf_lookups      (d1_perf_lookups),
      .perf_mispredicts  (d1_perf_mispredicts)
   );

   branch_predictor_bht #(.GHR_W(2), .PERF_W(4)) u_dut2 (
      .clk               (clk),
      .reset             (reset),
      .lookup_valid      (lookup_valid),
      .lookup_pc         (lookup_pc),
      .lookup_offset     (lookup_offset),
      .prediction        (d2_prediction),
      .branch_addr       (d2_branch_addr),
      .pred_index        (d2_pred_index),
      .update_valid      (update_valid),
      .update_index      (update_index),
      .update_taken      (update_taken),
      .update_mispredict (update_mispredict),
      .perf_lookups      (d2_perf_lookups),
      .perf_mispredicts  (d2_perf_mispredicts)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; the lookup-count model follows what the DUT saw at the edge.
   task automatic tick();
      @(posedge clk);
      if (reset) exp_lk = 0;
      else if (lookup_valid) exp_lk++;
      #1;
   endtask

   task automatic upd(input int idx, input bit tk, input bit mp);
      update_valid      = 1'b1;
      update_index      = 6'(idx);
      update_taken      = tk;
      update_mispredict = mp;
      tick();
      update_valid      = 1'b0;
      update_mispredict = 1'b0;
      #1;
   endtask

   task automatic look(input logic [31:0] pc);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      #1;
   endtask

   initial begin
      reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0; lookup_offset = '0;
      update_valid = 1'b0; update_index = '0; update_taken = 1'b0; update_mispredict = 1'b0;
      tick(); tick();
      reset = 1'b0; #1;
      chk("rst_perf_lookups", d1_perf_lookups, 0);
      chk("rst_perf_mispredicts", d1_perf_mispredicts, 0);

      lookup_offset = 32'h20;
      look(32'h100);
      chk("first_pred", d1_prediction, 0);
      chk("first_branch_addr", d1_branch_addr, 32'h120);
      chk("first_pred_index", d1_pred_index, 0);
      tick();
      lookup_valid = 1'b0; #1;
      chk("perf_lookups_one", d1_perf_lookups, 1);

      upd(5, 1, 0); upd(5, 1, 0);
      look(32'h14);
      chk("idx5_index", d1_pred_index, 5);
      chk("idx5_strong_taken", d1_prediction, 1);
      lookup_valid = 1'b0;
      upd(5, 0, 0); upd(5, 0, 0);
      look(32'h14);
      chk("idx5_back_not_taken", d1_prediction, 0);

      update_valid = 1'b1; update_index = 6'd5; update_taken = 1'b1; #1;
      chk("same_cycle_old_value", d1_prediction, 0);
      tick();
      update_valid = 1'b0; #1;
      chk("same_cycle_next_value", d1_prediction, 1);
      upd(5, 1, 0); upd(5, 1, 0); upd(5, 0, 0);
      chk("sat_high_then_dec", d1_prediction, 1);
      upd(5, 0, 0);
      chk("sat_high_dec_twice", d1_prediction, 0);
      lookup_valid = 1'b0; #1;
      chk("perf_lookups_model", d1_perf_lookups, 32'(exp_lk));

      upd(9, 1, 1); upd(9, 1, 1); upd(9, 1, 1);
      chk("mispredicts_three", d1_perf_mispredicts, 3);
      update_mispredict = 1'b1; tick(); update_mispredict = 1'b0; #1;
      chk("mispredict_no_valid", d1_perf_mispredicts, 3);
      upd(9, 0, 0);
      chk("valid_no_mispredict", d1_perf_mispredicts, 3);

      upd(7, 1, 0); upd(7, 1, 0);
      look(32'h1C);
      chk("idx7_trained", d1_prediction, 1);
      reset = 1'b1;
      update_valid = 1'b1; update_index = 6'd7; update_taken = 1'b1; update_mispredict = 1'b1; #1;
      chk("pred_during_reset", d1_prediction, 0);
      tick();
      reset = 1'b0; update_valid = 1'b0; update_mispredict = 1'b0; #1;
      chk("idx7_after_reset", d1_prediction, 0);
      chk("reset_perf_lookups", d1_perf_lookups, 32'(exp_lk));
      chk("reset_perf_mispredicts", d1_perf_mispredicts, 0);
      chk("reset_d2_mispredicts", d2_perf_mispredicts, 0);
      chk("reset_ghr_index", d2_pred_index, 7);
      lookup_valid = 1'b0;
      upd(7, 1, 0);
      look(32'h1C);
      chk("idx7_weak_plus_one", d1_prediction, 1);
      lookup_valid = 1'b0;

      reset = 1'b1; tick(); reset = 1'b0; #1;
      lookup_pc = 32'h0C; #1;
      chk("gshare_base", d2_pred_index, 3);
      upd(0, 1, 1); upd(0, 0, 1);
      chk("gshare_ghr10", d2_pred_index, 1);
      chk("bimodal_unaffected", d1_pred_index, 3);
      chk("d2_mispredicts_two", d2_perf_mispredicts, 2);
      repeat (12) upd(0, 0, 1);
      chk("d2_mispredicts_14", d2_perf_mispredicts, 14);
      upd(0, 0, 1);
      chk("d2_mispredicts_15", d2_perf_mispredicts, 15);
      repeat (5) upd(0, 0, 1);
      chk("d2_mispredicts_held", d2_perf_mispredicts, 15);
      chk("d1_mispredicts_20", d1_perf_mispredicts, 20);
      update_mispredict = 1'b1; tick(); update_mispredict = 1'b0; #1;
      chk("d2_no_valid_hold", d2_perf_mispredicts, 15);
      chk("d1_no_valid_hold", d1_perf_mispredicts, 20);
      chk("final_perf_lookups", d1_perf_lookups, 32'(exp_lk));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised successor to the single-FSM branch predictor in the sail-core pipeline: a table of ENTRIES saturating counters, indexed by the PC of the branch in decode.
- Optional gshare mode XORs a global history register (GHR) into the index.
- Combinational lookup in ID, synchronous training from the MEM-stage branch decision, plus saturating performance counters.
- Drop-in for the existing predictor mux path; the pipeline carries pred_index through ID/EX and EX/MEM and returns it at resolve.

Parameters:
- ADDR_W, 32, PC/offset/target width.
- ENTRIES, 64, counter table depth; power of two, 2..1024.
- CTR_W, 2, saturating counter width; 1..4.
- GHR_W, 0, global history bits; 0 = bimodal, 1..log2(ENTRIES) = gshare.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- lookup_valid  in  1  decode-stage branch signal (cont_mux_out[6] equivalent).
- lookup_pc  in  ADDR_W  PC of the decode instruction.
- lookup_offset  in  ADDR_W  immediate from imm_gen.
- prediction  out  1  predict taken.
- branch_addr  out  ADDR_W  predicted target.
- pred_index  out  IDX_W  table index used; carried down the pipeline.
- update_valid  in  1  MEM-stage branch resolves (branch_mem_sig).
- update_index  in  IDX_W  pred_index returned from EX/MEM.
- update_taken  in  1  actual_branch_decision.
- update_mispredict  in  1  Mispredict from branch_decision.
- perf_lookups  out  PERF_W  count of valid lookups.
- perf_mispredicts  out  PERF_W  count of mispredicted resolves.

Behaviour:
- IDX_W = log2(ENTRIES). The base index is lookup_pc[IDX_W+1:2].
- Bimodal: pred_index = base. Gshare: pred_index = base XOR zero-extended GHR.
- Lookup is purely combinational with zero latency:
  - prediction = lookup_valid & counter[pred_index] MSB.
  - branch_addr = lookup_pc + lookup_offset, truncated mod 2^ADDR_W; driven regardless of lookup_valid.
  - pred_index is driven regardless of lookup_valid.
- Counter update, on update_valid at the rising edge:
  - update_taken = 1: counter[update_index] increments, saturating at 2^CTR_W-1.
  - update_taken = 0: counter[update_index] decrements, saturating at 0.
- GHR update, on update_valid at the rising edge: GHR <= {GHR[GHR_W-2:0], update_taken}. For GHR_W=1 the GHR is loaded with update_taken. The GHR is non-speculative: it changes only at resolve, so no recovery logic is needed.
- Same-cycle lookup and update hitting the same index: the lookup sees the pre-update counter value; the new value is visible the next cycle.
- perf_lookups increments on every cycle with lookup_valid=1.
- perf_mispredicts increments when update_valid & update_mispredict.
- Both perf counters saturate at all-ones and never wrap.
- update_mispredict without update_valid is ignored.
- Reset, synchronous, single cycle:
  - All counters go to weakly-not-taken, 2^(CTR_W-1)-1; for CTR_W=1 that is 0.
  - GHR goes to 0 and both perf counters go to 0.
  - An update coincident with reset is discarded; reset wins.
  - Outputs during and after reset: prediction = lookup_valid & 0 = 0 in the reset cycle; branch_addr and pred_index stay combinational.
- Reset mid-operation: in-flight pred_index values still held in pipeline registers become stale. Updates using them after reset are legal and simply train the addressed entry.
- No stall or backpressure: lookup and update are each accepted every cycle.
- Counter storage is flops; no RAM inference is required up to 1024 entries.

Decomposition:
- Shared package bp_pkg holds:
  - the clog2 helper;
  - the function ctr_init(CTR_W);
  - the saturating-increment and saturating-decrement functions;
  - the localparam IDX_W expression.
- One natural sub-module: sat_counter (parameter W, ports clk, reset, inc, dec, init value, q). It is instantiated ENTRIES times for the table and reused with W=PERF_W for the two perf counters, with dec tied low.

Test Plan:
- Reset, then lookup_valid=1, lookup_pc=0x100, lookup_offset=0x20 -> prediction=0, branch_addr=0x120, pred_index=0 (ENTRIES=64), perf_lookups=1 next cycle.
- Two taken updates on index 5 (01->10->11), then lookup at pc=0x14 -> prediction=1. Two not-taken updates -> prediction=0.
- Same-cycle lookup and taken update at index 5 with counter=01 -> prediction=0 that cycle, 1 the next cycle. A third taken update at 11 stays at 11 (saturation).
- GHR_W=2: taken, not-taken resolves give GHR=2'b10; lookup pc=0x0C (base 3) -> pred_index=1.
- PERF_W=4: 20 mispredicting updates -> perf_mispredicts=15, held there. update_mispredict=1 with update_valid=0 -> no change.
- Assert reset with update_valid=1 on index 7 -> entry 7 stays 01, GHR=0, perf counters=0.
